id_pool_arbiter: RTL and testbench
==================================

ID_POOL_ARBITER -- requirements
Module: id_pool_arbiter

Interface
REQ-001 NUM_REQ, 4, number of ID requesters.
REQ-002 NUM_IDS, 8, IDs in the attached pool; ID_W = 3.
REQ-003 MAX_OUTSTANDING, 4, maximum IDs held by one requester at once.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 io_req_valid  in  NUM_REQ  per-requester allocation request.
REQ-007 io_req_ready  out  NUM_REQ  one-hot grant, same cycle as request.
REQ-008 io_req_id  out  ID_W  granted ID, meaningful when any io_req_ready bit is high.
REQ-009 io_free_valid  in  1  ID release strobe.
REQ-010 io_free_bits  in  ID_W  released ID.
REQ-011 io_free_owner_valid  out  1  registered release acknowledge.
REQ-012 io_free_owner  out  2  requester index that owned the released ID.
REQ-013 io_free_err  out  1  registered pulse: release of an ID not currently owned.
REQ-014 pool_alloc_valid  in  1  pool has a free ID.
REQ-015 pool_alloc_bits  in  ID_W  pool's offered ID.
REQ-016 pool_alloc_ready  out  1  pool ID consumed this cycle.
REQ-017 pool_free_valid  out  1  return ID to pool.
REQ-018 pool_free_bits  out  ID_W  ID returned to pool.

Function
REQ-019 Requester i eligible when io_req_valid[i] and count[i] < MAX_OUTSTANDING.
REQ-020 Grant only when pool_alloc_valid; pick first eligible requester searching upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-021 io_req_ready = one-hot grant (combinational); pool_alloc_ready = OR of grant; io_req_id = pool_alloc_bits.
REQ-022 No eligible requester or pool_alloc_valid low: io_req_ready = 0, pool_alloc_ready = 0, no state change from the grant path.
REQ-023 On grant to i at edge: owned[id] <= 1, owner[id] <= i, count[i] += 1, rr_ptr <= (i+1) mod NUM_REQ.
REQ-024 Free sampled at cycle T; if owned[id]: owned[id] cleared and count[owner[id]] -= 1 at the T edge; at T+1 pool_free_valid = 1, pool_free_bits = id, io_free_owner_valid = 1, io_free_owner = owner.
REQ-025 Free of unowned ID (including duplicate free): no state change, nothing forwarded; io_free_err = 1 at T+1 only.
REQ-026 Grant and valid free for the same requester in one cycle: count net unchanged.
REQ-027 Grant of ID X and free of ID X in the same cycle cannot occur (pool cannot re-offer X before T+1 return); bench asserts it.
REQ-028 count[i] is 3 bits, never exceeds MAX_OUTSTANDING, never underflows.
REQ-029 All registered outputs (pool_free_*, io_free_owner*, io_free_err) are single-cycle pulses, 0 when no free at T.

Reset
REQ-030 Reset clears owned[], owner[], count[], rr_ptr to 0 and all registered outputs to 0 immediately, regardless of clock.
REQ-031 Reset mid-operation discards outstanding ownership; the pool is reset by the same signal.

Structure
REQ-032 Package id_pool_arb_pkg holds NUM_REQ, NUM_IDS, ID_W, MAX_OUTSTANDING, typedefs id_t and req_idx_t.
REQ-033 One sub-module rr_arb (NUM_REQ-wide round-robin picker: eligible vector and pointer in, one-hot grant out).

Verification
REQ-034 All 4 requesting, pool valid IDs 0,1,2,3 on consecutive cycles -> grants to requesters 0,1,2,3 in order, io_req_id 0..3.
REQ-035 Requester 2 alone receives 4 IDs, keeps requesting -> no further grant while count[2]=4; requester 3 request granted next pool-valid cycle.
REQ-036 Free ID 5 owned by requester 1 at T -> T+1: pool_free_valid=1, pool_free_bits=5, io_free_owner=1; count[1] decremented.
REQ-037 Free ID 6 never granted -> T+1: io_free_err=1, pool_free_valid=0, counts unchanged.
REQ-038 Requester 0 at count 4 frees one ID and requests same cycle with pool valid -> grant issued, count stays 4.
REQ-039 Assert reset asynchronously between clock edges with 3 IDs outstanding -> outputs and counts 0 before next edge; first grant after release goes to requester 0.

Source files
------------

// File: rtl/id_pool_arb_pkg.sv
// Shared sizing, types and a one-hot encoder for the ID pool arbiter.
package id_pool_arb_pkg;

  localparam int NUM_REQ         = 4;
  localparam int NUM_IDS         = 8;
  localparam int ID_W            = 3;
  localparam int MAX_OUTSTANDING = 4;
  localparam int REQ_W           = 2;
  localparam int CNT_W           = 3;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [REQ_W-1:0] req_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Encode a one-hot (or all-zero) requester vector into its index.
  function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) begin
        idx = idx | req_idx_t'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/id_pool_arbiter_rr_arb.sv
// Round-robin picker: first eligible requester at or above ptr, wrapping.
module rr_arb
  import id_pool_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  req_idx_t           ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic     found_s;
  req_idx_t idx_s;

  // Scan upward from the pointer and take the first eligible requester.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = req_idx_t'((int'(ptr) + k) % NUM_REQ);
      if (!found_s && eligible[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/id_pool_arbiter.sv
// Hands pool IDs to requesters round-robin, tracks ownership and
// per-requester outstanding counts, and forwards releases back to the pool.
module id_pool_arbiter
  import id_pool_arb_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] io_req_valid,
  output logic [NUM_REQ-1:0] io_req_ready,
  output logic [ID_W-1:0]    io_req_id,
  input  logic               io_free_valid,
  input  logic [ID_W-1:0]    io_free_bits,
  output logic               io_free_owner_valid,
  output logic [REQ_W-1:0]   io_free_owner,
  output logic               io_free_err,
  input  logic               pool_alloc_valid,
  input  logic [ID_W-1:0]    pool_alloc_bits,
  output logic               pool_alloc_ready,
  output logic               pool_free_valid,
  output logic [ID_W-1:0]    pool_free_bits
);

  logic [NUM_IDS-1:0]            owned_q, owned_d;
  logic [NUM_IDS-1:0][REQ_W-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] count_q, count_d;
  req_idx_t                      rr_ptr_q, rr_ptr_d;

  logic     pool_free_valid_q, pool_free_valid_d;
  id_t      pool_free_bits_q, pool_free_bits_d;
  logic     io_free_owner_valid_q, io_free_owner_valid_d;
  req_idx_t io_free_owner_q, io_free_owner_d;
  logic     io_free_err_q, io_free_err_d;

  logic               free_hit_s;
  req_idx_t           free_owner_s;
  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               any_grant_s;
  req_idx_t           grant_idx_s;

  // Release lookup and eligibility; a same-cycle release frees a slot for its owner.
  always_comb begin
    free_hit_s   = io_free_valid && owned_q[io_free_bits];
    free_owner_s = owner_q[io_free_bits];
    eligible_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = pool_alloc_valid && io_req_valid[i] &&
                      ((count_q[i] < cnt_t'(MAX_OUTSTANDING)) ||
                       (free_hit_s && (free_owner_s == req_idx_t'(i))));
    end
  end

  rr_arb u_rr_arb (
    .eligible (eligible_s),
    .ptr      (rr_ptr_q),
    .grant    (grant_s)
  );

  // Next-state: release first, then grant, so a shared requester nets to zero.
  always_comb begin
    any_grant_s = |grant_s;
    grant_idx_s = onehot_to_idx(grant_s);
    owned_d     = owned_q;
    owner_d     = owner_q;
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    if (free_hit_s) begin
      owned_d[io_free_bits]  = 1'b0;
      count_d[free_owner_s]  = count_d[free_owner_s] - cnt_t'(1);
    end else begin
      owned_d = owned_d;
    end
    if (any_grant_s) begin
      owned_d[pool_alloc_bits] = 1'b1;
      owner_d[pool_alloc_bits] = grant_idx_s;
      count_d[grant_idx_s]     = count_d[grant_idx_s] + cnt_t'(1);
      rr_ptr_d                 = req_idx_t'((int'(grant_idx_s) + 1) % NUM_REQ);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    pool_free_valid_d     = free_hit_s;
    pool_free_bits_d      = free_hit_s ? io_free_bits : '0;
    io_free_owner_valid_d = free_hit_s;
    io_free_owner_d       = free_hit_s ? free_owner_s : '0;
    io_free_err_d         = io_free_valid && !owned_q[io_free_bits];
  end

  // State and registered release outputs; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owned_q               <= '0;
      owner_q               <= '0;
      count_q               <= '0;
      rr_ptr_q              <= '0;
      pool_free_valid_q     <= 1'b0;
      pool_free_bits_q      <= '0;
      io_free_owner_valid_q <= 1'b0;
      io_free_owner_q       <= '0;
      io_free_err_q         <= 1'b0;
    end else begin
      owned_q               <= owned_d;
      owner_q               <= owner_d;
      count_q               <= count_d;
      rr_ptr_q              <= rr_ptr_d;
      pool_free_valid_q     <= pool_free_valid_d;
      pool_free_bits_q      <= pool_free_bits_d;
      io_free_owner_valid_q <= io_free_owner_valid_d;
      io_free_owner_q       <= io_free_owner_d;
      io_free_err_q         <= io_free_err_d;
    end
  end

  assign io_req_ready        = grant_s;
  assign io_req_id           = pool_alloc_bits;
  assign pool_alloc_ready    = any_grant_s;
  assign pool_free_valid     = pool_free_valid_q;
  assign pool_free_bits      = pool_free_bits_q;
  assign io_free_owner_valid = io_free_owner_valid_q;
  assign io_free_owner       = io_free_owner_q;
  assign io_free_err         = io_free_err_q;

endmodule

// File: tb/tb_id_pool_arbiter.sv
// Directed bench for id_pool_arbiter with hand-computed expectations.
module tb_id_pool_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] io_req_valid;
  logic [3:0] io_req_ready;
  logic [2:0] io_req_id;
  logic       io_free_valid;
  logic [2:0] io_free_bits;
  logic       io_free_owner_valid;
  logic [1:0] io_free_owner;
  logic       io_free_err;
  logic       pool_alloc_valid;
  logic [2:0] pool_alloc_bits;
  logic       pool_alloc_ready;
  logic       pool_free_valid;
  logic [2:0] pool_free_bits;

  int n_vec = 0;
  int n_err = 0;

  id_pool_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .io_req_valid        (io_req_valid),
    .io_req_ready        (io_req_ready),
    .io_req_id           (io_req_id),
    .io_free_valid       (io_free_valid),
    .io_free_bits        (io_free_bits),
    .io_free_owner_valid (io_free_owner_valid),
    .io_free_owner       (io_free_owner),
    .io_free_err         (io_free_err),
    .pool_alloc_valid    (pool_alloc_valid),
    .pool_alloc_bits     (pool_alloc_bits),
    .pool_alloc_ready    (pool_alloc_ready),
    .pool_free_valid     (pool_free_valid),
    .pool_free_bits      (pool_free_bits)
  );

  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs just after an edge and let combinational outputs settle.
  task automatic drive(input logic [3:0] rv, input logic fv, input logic [2:0] fb,
                       input logic pv, input logic [2:0] pb);
    io_req_valid     = rv;
    io_free_valid    = fv;
    io_free_bits     = fb;
    pool_alloc_valid = pv;
    pool_alloc_bits  = pb;
    #2;
    check_vec("no_same_id_grant_free",
              32'(io_free_valid && pool_alloc_ready && (io_free_bits == pool_alloc_bits)), 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_comb(input string tag, input logic [3:0] exp_ready, input logic [2:0] exp_id);
    check_vec({tag, "_ready"}, 32'(io_req_ready), 32'(exp_ready));
    check_vec({tag, "_alloc_ready"}, 32'(pool_alloc_ready), 32'(exp_ready != 4'd0));
    if (exp_ready != 4'd0) check_vec({tag, "_id"}, 32'(io_req_id), 32'(exp_id));
  endtask

  task automatic check_free(input string tag, input logic pfv, input logic [2:0] pfb,
                            input logic ov, input logic [1:0] ow, input logic err);
    check_vec({tag, "_pool_free_valid"}, 32'(pool_free_valid), 32'(pfv));
    check_vec({tag, "_pool_free_bits"}, 32'(pool_free_bits), 32'(pfb));
    check_vec({tag, "_owner_valid"}, 32'(io_free_owner_valid), 32'(ov));
    check_vec({tag, "_owner"}, 32'(io_free_owner), 32'(ow));
    check_vec({tag, "_err"}, 32'(io_free_err), 32'(err));
  endtask

  initial begin
    reset            = 1'b1;
    io_req_valid     = 4'd0;
    io_free_valid    = 1'b0;
    io_free_bits     = 3'd0;
    pool_alloc_valid = 1'b0;
    pool_alloc_bits  = 3'd0;
    #1;
    check_free("reset", 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
    check_comb("reset", 4'd0, 3'd0);
    step();
    reset = 1'b0;

    // All four requesting: strict rotation 0,1,2,3 with ids 0..3.
    for (int k = 0; k < 4; k++) begin
      drive(4'hF, 1'b0, 3'd0, 1'b1, 3'(k));
      check_comb($sformatf("rot%0d", k), 4'(1 << k), 3'(k));
      step();
    end

    // Requester 1 takes id 5, then releases it.
    drive(4'b0010, 1'b0, 3'd0, 1'b1, 3'd5);
    check_comb("r1_id5", 4'b0010, 3'd5);
    step();
    drive(4'b0000, 1'b1, 3'd5, 1'b0, 3'd0);
    check_comb("free5_nogrant", 4'd0, 3'd0);
    step();
    check_free("free5", 1'b1, 3'd5, 1'b1, 2'd1, 1'b0);
    check_vec("free5_count1", 32'(dut.count_q[1]), 32'd1);
    drive(4'b0000, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    check_free("free5_pulse", 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);

    // Release of a never-granted id and a duplicate release both flag an error.
    drive(4'b0000, 1'b1, 3'd6, 1'b0, 3'd0);
    step();
    check_free("free6", 1'b0, 3'd0, 1'b0, 2'd0, 1'b1);
    check_vec("free6_counts", 32'(dut.count_q), 32'h0000_0249);
    drive(4'b0000, 1'b1, 3'd5, 1'b0, 3'd0);
    step();
    check_free("dup5", 1'b0, 3'd0, 1'b0, 2'd0, 1'b1);

    // Release id 3, then reset asynchronously while the acknowledge is high.
    drive(4'b0000, 1'b1, 3'd3, 1'b0, 3'd0);
    step();
    check_free("free3", 1'b1, 3'd3, 1'b1, 2'd3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_free("async_rst", 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
    check_vec("async_rst_counts", 32'(dut.count_q), 32'd0);
    step();
    reset = 1'b0;
    drive(4'hF, 1'b0, 3'd0, 1'b1, 3'd0);
    check_comb("post_rst", 4'b0001, 3'd0);
    step();

    // Requester 2 alone fills to the limit, then is blocked; requester 3 gets in.
    for (int k = 1; k < 5; k++) begin
      drive(4'b0100, 1'b0, 3'd0, 1'b1, 3'(k));
      check_comb($sformatf("r2_fill%0d", k), 4'b0100, 3'(k));
      step();
    end
    for (int k = 0; k < 2; k++) begin
      drive(4'b0100, 1'b0, 3'd0, 1'b1, 3'd5);
      check_comb($sformatf("r2_full%0d", k), 4'd0, 3'd0);
      step();
    end
    check_vec("r2_count", 32'(dut.count_q[2]), 32'd4);
    drive(4'b1100, 1'b0, 3'd0, 1'b1, 3'd5);
    check_comb("r3_gets", 4'b1000, 3'd5);
    step();

    // Return two of requester 2's ids so requester 0 can fill to the limit.
    drive(4'b0000, 1'b1, 3'd1, 1'b0, 3'd0);
    step();
    check_free("free1", 1'b1, 3'd1, 1'b1, 2'd2, 1'b0);
    drive(4'b0000, 1'b1, 3'd2, 1'b0, 3'd0);
    step();
    check_free("free2", 1'b1, 3'd2, 1'b1, 2'd2, 1'b0);
    drive(4'b0001, 1'b0, 3'd0, 1'b1, 3'd6);
    check_comb("r0_id6", 4'b0001, 3'd6);
    step();
    drive(4'b0001, 1'b0, 3'd0, 1'b1, 3'd7);
    check_comb("r0_id7", 4'b0001, 3'd7);
    step();
    drive(4'b0001, 1'b0, 3'd0, 1'b1, 3'd1);
    check_comb("r0_id1", 4'b0001, 3'd1);
    step();
    drive(4'b0001, 1'b0, 3'd0, 1'b1, 3'd2);
    check_comb("r0_full", 4'd0, 3'd0);
    step();

    // At the limit, a same-cycle release lets requester 0 take a new id; count stays 4.
    drive(4'b0001, 1'b1, 3'd0, 1'b1, 3'd2);
    check_comb("r0_swap", 4'b0001, 3'd2);
    step();
    check_free("r0_swap", 1'b1, 3'd0, 1'b1, 2'd0, 1'b0);
    check_vec("r0_swap_count", 32'(dut.count_q[0]), 32'd4);
    drive(4'b0000, 1'b0, 3'd0, 1'b0, 3'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
